// File: rtl/triangle_vertex_anim.sv
// Per-frame triangle vertex animator: steps three vertices with border bounce,
// updating one vertex per cycle through a shared adder and committing all six coordinates at once.
module triangle_vertex_anim #(
    parameter int XMIN      = 285,
    parameter int XMAX      = 1554,
    parameter int YMIN      = 35,
    parameter int YMAX      = 514,
    parameter int STEP_X    = 4,
    parameter int STEP_Y    = 2,
    parameter int FRAME_DIV = 1
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        frame_start,
    input  logic        enable,
    output logic [10:0] x0,
    output logic [10:0] x1,
    output logic [10:0] x2,
    output logic [9:0]  y0,
    output logic [9:0]  y1,
    output logic [9:0]  y2,
    output logic        upd
);

    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(FRAME_DIV - 1);

    localparam logic [11:0] C_XMIN   = 12'(XMIN);
    localparam logic [11:0] C_XMAX   = 12'(XMAX);
    localparam logic [11:0] C_YMIN   = 12'(YMIN);
    localparam logic [11:0] C_YMAX   = 12'(YMAX);
    localparam logic [11:0] C_STEP_X = 12'(STEP_X);
    localparam logic [11:0] C_STEP_Y = 12'(STEP_Y);

    localparam logic [10:0] C_X0_INIT = 11'd700;
    localparam logic [10:0] C_X1_INIT = 11'd330;
    localparam logic [10:0] C_X2_INIT = 11'd1350;
    localparam logic [9:0]  C_Y0_INIT = 10'd70;
    localparam logic [9:0]  C_Y1_INIT = 10'd300;
    localparam logic [9:0]  C_Y2_INIT = 10'd215;

    // IDLE: wait for frame_start / V0..V2: step one working vertex / COMMIT: publish set, pulse upd
    typedef enum logic [2:0] {S_IDLE, S_V0, S_V1, S_V2, S_COMMIT} state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div_cnt;
    logic [10:0]      r_wx0, r_wx1, r_wx2;
    logic [9:0]       r_wy0, r_wy1, r_wy2;
    logic [2:0]       r_dx, r_dy;

    logic [10:0] w_cur_x, w_nx;
    logic [9:0]  w_cur_y, w_ny;
    logic        w_cur_dx, w_cur_dy, w_ndx, w_ndy;
    logic [11:0] w_x12, w_y12, w_x_inc, w_x_dec, w_y_inc, w_y_dec;

    // The state selects which working vertex feeds the shared step logic.
    always_comb begin
        w_cur_x  = r_wx0;
        w_cur_y  = r_wy0;
        w_cur_dx = r_dx[0];
        w_cur_dy = r_dy[0];
        case (r_state)
            S_V1: begin
                w_cur_x  = r_wx1;
                w_cur_y  = r_wy1;
                w_cur_dx = r_dx[1];
                w_cur_dy = r_dy[1];
            end
            S_V2: begin
                w_cur_x  = r_wx2;
                w_cur_y  = r_wy2;
                w_cur_dx = r_dx[2];
                w_cur_dy = r_dy[2];
            end
            default: ;
        endcase
    end

    assign w_x12   = {1'b0, w_cur_x};
    assign w_y12   = {2'b00, w_cur_y};
    assign w_x_inc = w_x12 + C_STEP_X;
    assign w_x_dec = w_x12 - C_STEP_X;
    assign w_y_inc = w_y12 + C_STEP_Y;
    assign w_y_dec = w_y12 - C_STEP_Y;

    always_comb begin
        w_nx  = w_cur_x;
        w_ndx = w_cur_dx;
        if (w_cur_dx) begin
            if (w_x_inc >= C_XMAX) begin
                w_nx  = 11'(C_XMAX);
                w_ndx = 1'b0;
            end else begin
                w_nx = 11'(w_x_inc);
            end
        end else if (w_x12 <= C_XMIN + C_STEP_X) begin
            w_nx  = 11'(C_XMIN);
            w_ndx = 1'b1;
        end else begin
            w_nx = 11'(w_x_dec);
        end
    end

    always_comb begin
        w_ny  = w_cur_y;
        w_ndy = w_cur_dy;
        if (w_cur_dy) begin
            if (w_y_inc >= C_YMAX) begin
                w_ny  = 10'(C_YMAX);
                w_ndy = 1'b0;
            end else begin
                w_ny = 10'(w_y_inc);
            end
        end else if (w_y12 <= C_YMIN + C_STEP_Y) begin
            w_ny  = 10'(C_YMIN);
            w_ndy = 1'b1;
        end else begin
            w_ny = 10'(w_y_dec);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= S_IDLE;
            r_div_cnt <= '0;
            r_wx0 <= C_X0_INIT;  r_wy0 <= C_Y0_INIT;
            r_wx1 <= C_X1_INIT;  r_wy1 <= C_Y1_INIT;
            r_wx2 <= C_X2_INIT;  r_wy2 <= C_Y2_INIT;
            r_dx  <= 3'b101;
            r_dy  <= 3'b011;
            x0 <= C_X0_INIT;  y0 <= C_Y0_INIT;
            x1 <= C_X1_INIT;  y1 <= C_Y1_INIT;
            x2 <= C_X2_INIT;  y2 <= C_Y2_INIT;
            upd <= 1'b0;
        end else begin
            upd <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (frame_start && enable) begin
                        if (r_div_cnt == C_DIV_LAST) begin
                            r_div_cnt <= '0;
                            r_state   <= S_V0;
                        end else begin
                            r_div_cnt <= r_div_cnt + DIV_W'(1);
                        end
                    end
                end
                S_V0: begin
                    r_wx0   <= w_nx;
                    r_wy0   <= w_ny;
                    r_dx[0] <= w_ndx;
                    r_dy[0] <= w_ndy;
                    r_state <= S_V1;
                end
                S_V1: begin
                    r_wx1   <= w_nx;
                    r_wy1   <= w_ny;
                    r_dx[1] <= w_ndx;
                    r_dy[1] <= w_ndy;
                    r_state <= S_V2;
                end
                S_V2: begin
                    r_wx2   <= w_nx;
                    r_wy2   <= w_ny;
                    r_dx[2] <= w_ndx;
                    r_dy[2] <= w_ndy;
                    r_state <= S_COMMIT;
                end
                S_COMMIT: begin
                    x0 <= r_wx0;  y0 <= r_wy0;
                    x1 <= r_wx1;  y1 <= r_wy1;
                    x2 <= r_wx2;  y2 <= r_wy2;
                    upd     <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_vertex_anim.sv
// Bench for triangle_vertex_anim: scoreboard of expected vertex sets popped on upd,
// a table of enable/pulse vectors, and hand sequences for timing, reset, bounce and divider.
module tb_triangle_vertex_anim;

    logic        CLOCK_50;
    logic        RESET_N;
    logic        frame_start, fs3, enable;
    logic [10:0] x0, x1, x2, x0_3, x1_3, x2_3;
    logic [9:0]  y0, y1, y2, y0_3, y1_3, y2_3;
    logic        upd, upd3;

    triangle_vertex_anim dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .frame_start(frame_start), .enable(enable),
        .x0(x0), .x1(x1), .x2(x2), .y0(y0), .y1(y1), .y2(y2), .upd(upd)
    );

    triangle_vertex_anim #(.FRAME_DIV(3)) dut3 (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .frame_start(fs3), .enable(enable),
        .x0(x0_3), .x1(x1_3), .x2(x2_3), .y0(y0_3), .y1(y1_3), .y2(y2_3), .upd(upd3)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    typedef struct {
        int x0, x1, x2, y0, y1, y2;
    } set_t;

    typedef struct {
        bit en;
        int gap;
        int exp_upd;
    } vec_t;

    set_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   upd_cnt = 0;
    int   upd3_cnt = 0;

    int mx[3], my[3];
    bit mdx[3], mdy[3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mx = '{700, 330, 1350};
        my = '{70, 300, 215};
        mdx = '{1'b1, 1'b0, 1'b1};
        mdy = '{1'b1, 1'b1, 1'b0};
        q.delete();
    endtask

    task automatic step_axis(inout int p, inout bit d, input int lo, input int hi, input int st);
        if (d) begin
            if (p + st >= hi) begin p = hi; d = 1'b0; end
            else p = p + st;
        end else begin
            if (p <= lo + st) begin p = lo; d = 1'b1; end
            else p = p - st;
        end
    endtask

    // Main DUT uses FRAME_DIV=1, so every enabled pulse in IDLE is an update.
    task automatic model_frame();
        set_t s;
        if (enable) begin
            for (int i = 0; i < 3; i++) begin
                step_axis(mx[i], mdx[i], 285, 1554, 4);
                step_axis(my[i], mdy[i], 35, 514, 2);
            end
            s.x0 = mx[0]; s.x1 = mx[1]; s.x2 = mx[2];
            s.y0 = my[0]; s.y1 = my[1]; s.y2 = my[2];
            q.push_back(s);
        end
    endtask

    task automatic tick();
        set_t e;
        @(negedge CLOCK_50);
        if (upd3 === 1'b1) upd3_cnt++;
        if (upd === 1'b1) begin
            upd_cnt++;
            if (q.size() == 0) begin
                chk("unexpected_upd", 1, 0);
            end else begin
                e = q.pop_front();
                chk("sb_x0", x0, e.x0);
                chk("sb_y0", y0, e.y0);
                chk("sb_x1", x1, e.x1);
                chk("sb_y1", y1, e.y1);
                chk("sb_x2", x2, e.x2);
                chk("sb_y2", y2, e.y2);
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input bit model_sees);
        frame_start = 1'b1;
        if (model_sees) model_frame();
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pulse3();
        fs3 = 1'b1;
        tick();
        fs3 = 1'b0;
        ticks(9);
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        ticks(2);
        model_reset();
        RESET_N = 1'b1;
        tick();
    endtask

    task automatic chk_initial(input string tag);
        chk({tag, "_x0"}, x0, 700);
        chk({tag, "_y0"}, y0, 70);
        chk({tag, "_x1"}, x1, 330);
        chk({tag, "_y1"}, y1, 300);
        chk({tag, "_x2"}, x2, 1350);
        chk({tag, "_y2"}, y2, 215);
        chk({tag, "_upd"}, upd, 0);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_x0"}, x0, mx[0]);
        chk({tag, "_y0"}, y0, my[0]);
        chk({tag, "_x1"}, x1, mx[1]);
        chk({tag, "_y1"}, y1, my[1]);
        chk({tag, "_x2"}, x2, mx[2]);
        chk({tag, "_y2"}, y2, my[2]);
    endtask

    vec_t vecs[8];
    int   base;
    int   exp3;

    initial begin
        vecs[0] = '{1'b0, 10, 0};
        vecs[1] = '{1'b0, 10, 0};
        vecs[2] = '{1'b0, 10, 0};
        vecs[3] = '{1'b0, 10, 0};
        vecs[4] = '{1'b0, 10, 0};
        vecs[5] = '{1'b1, 10, 1};
        vecs[6] = '{1'b1, 6, 1};
        vecs[7] = '{1'b0, 8, 0};

        RESET_N = 1'b0;
        frame_start = 1'b0;
        fs3 = 1'b0;
        enable = 1'b1;
        model_reset();
        ticks(3);
        chk_initial("reset");
        RESET_N = 1'b1;
        tick();

        // single update with cycle-exact timing
        pulse(1'b1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("pre_commit_x0", x0, 700);
            chk("pre_commit_x2", x2, 1350);
            chk("pre_commit_upd", upd, 0);
        end
        base = upd_cnt;
        tick();
        chk("commit_upd", upd, 1);
        chk("commit_cnt", upd_cnt - base, 1);
        chk("single_x0", x0, 704);
        chk("single_y0", y0, 72);
        chk("single_x1", x1, 326);
        chk("single_y1", y1, 302);
        chk("single_x2", x2, 1354);
        chk("single_y2", y2, 213);
        tick();
        chk("upd_one_cycle", upd, 0);
        ticks(4);

        // second pulse two cycles after the first is ignored
        do_reset();
        base = upd_cnt;
        pulse(1'b1);
        tick();
        pulse(1'b0);
        ticks(10);
        chk("ignored_upd_cnt", upd_cnt - base, 1);
        chk("ignored_x0", x0, 704);

        // asynchronous reset while the FSM is in V1
        do_reset();
        pulse(1'b1);
        tick();
        #2 RESET_N = 1'b0;
        #1;
        chk_initial("async_rst");
        model_reset();
        ticks(2);
        RESET_N = 1'b1;
        base = upd_cnt;
        ticks(10);
        chk("rst_no_upd", upd_cnt - base, 0);
        chk_initial("rst_hold");
        pulse(1'b1);
        ticks(9);
        chk("rst_next_upd", upd_cnt - base, 1);
        chk("rst_next_x0", x0, 704);

        // bounce against right border in x and top border in y
        do_reset();
        for (int p = 1; p <= 91; p++) begin
            pulse(1'b1);
            ticks(9);
            if (p == 51) chk("bounce_x2_clamp", x2, 1554);
            if (p == 52) chk("bounce_x2_back", x2, 1550);
            if (p == 90) chk("bounce_y2_clamp", y2, 35);
            if (p == 91) chk("bounce_y2_back", y2, 37);
        end
        chk("bounce_queue_empty", q.size(), 0);

        // enable/pulse vectors, including freeze
        for (int v = 0; v < 8; v++) begin
            enable = vecs[v].en;
            base = upd_cnt;
            pulse(1'b1);
            ticks(vecs[v].gap - 1);
            chk("vec_upd_cnt", upd_cnt - base, vecs[v].exp_upd);
            chk_model("vec_out");
        end

        // enable dropped mid-update still completes
        enable = 1'b1;
        base = upd_cnt;
        pulse(1'b1);
        tick();
        enable = 1'b0;
        ticks(8);
        chk("en_drop_upd_cnt", upd_cnt - base, 1);
        chk_model("en_drop");
        enable = 1'b1;

        // divider: updates after pulses 3 and 6 only
        do_reset();
        for (int p = 1; p <= 6; p++) begin
            base = upd3_cnt;
            pulse3();
            exp3 = (p % 3 == 0) ? 1 : 0;
            chk("div_upd_per_pulse", upd3_cnt - base, exp3);
        end
        chk("div_x0", x0_3, 708);
        chk("div_y0", y0_3, 74);

        // divider count holds while frozen
        do_reset();
        base = upd3_cnt;
        pulse3();
        enable = 1'b0;
        for (int p = 0; p < 5; p++) pulse3();
        enable = 1'b1;
        pulse3();
        chk("div_freeze_none", upd3_cnt - base, 0);
        pulse3();
        chk("div_freeze_resume", upd3_cnt - base, 1);
        chk("div_freeze_x0", x0_3, 704);
        chk("main_idle_no_upd_q", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
